// File: rtl/window_stream_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_stream_gen_pkg
// Description : Shared definitions for the 3x3 window stream generator:
//               frame geometry defaults, control-state encoding, tap indices
//               inside the packed window and the flush length.
// Revision    : 1.0 - initial release
// ============================================================================
package window_stream_gen_pkg;

    // Default frame geometry and pixel width
    localparam int WIDTH_DEF = 410;
    localparam int DEPTH_DEF = 361;
    localparam int PIX_W_DEF = 8;

    // Coordinate width for x/y counters and the window centre outputs
    localparam int COORD_W = 9;

    // Virtual zero pixels needed after the last real pixel so that the
    // bottom-right window reaches the output registers
    localparam int FLUSH_LEN = WIDTH_DEF + 1;

    // Tap k = (dy+1)*3 + (dx+1) inside the packed window
    localparam int TAP_NW = 0;
    localparam int TAP_N  = 1;
    localparam int TAP_NE = 2;
    localparam int TAP_W  = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_E  = 5;
    localparam int TAP_SW = 6;
    localparam int TAP_S  = 7;
    localparam int TAP_SE = 8;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/window_stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : window_stream_gen_if
// Description : Pixel-in / window-out handshake bundle of the window stream
//               generator.
//               master : producer of pixels and consumer of windows
//               slave  : the window generator itself
//               Signals: pix_in, pix_valid, pix_ready (pixel side),
//                        win_out, win_x, win_y, win_valid, win_ready,
//                        frame_done (window side)
// Revision    : 1.0 - initial release
// ============================================================================
interface window_stream_gen_if
    import window_stream_gen_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) ();

    logic [PIX_W-1:0]   pix_in;
    logic               pix_valid;
    logic               pix_ready;
    logic [9*PIX_W-1:0] win_out;
    logic [COORD_W-1:0] win_x;
    logic [COORD_W-1:0] win_y;
    logic               win_valid;
    logic               win_ready;
    logic               frame_done;

    modport master (
        output pix_in,
        output pix_valid,
        input  pix_ready,
        input  win_out,
        input  win_x,
        input  win_y,
        input  win_valid,
        output win_ready,
        input  frame_done
    );

    modport slave (
        input  pix_in,
        input  pix_valid,
        output pix_ready,
        output win_out,
        output win_x,
        output win_y,
        output win_valid,
        input  win_ready,
        output frame_done
    );

endinterface
`default_nettype wire

// File: rtl/window_stream_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_stream_gen_line_buffer
// Description : LEN-deep circular delay line. On each enabled cycle the
//               sample written LEN enables ago appears on dout (read before
//               write at the same slot) and din replaces it.
//               Ports: clk, rst (clears the pointer only), en (shift enable),
//                      din (sample in), dout (sample delayed by LEN shifts)
// Revision    : 1.0 - initial release
// ============================================================================
module window_stream_gen_line_buffer
    import window_stream_gen_pkg::*;
#(
    parameter int LEN   = WIDTH_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic [PIX_W-1:0] din,
    output logic      [PIX_W-1:0] dout
);

    localparam int                c_PTR_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(LEN - 1);

    // Storage is never cleared: stale contents only ever feed taps that the
    // border mask forces to zero.
    logic [PIX_W-1:0]   r_mem [LEN];
    logic [c_PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_ptr] <= din;
        end
    end

    assign dout = r_mem[r_ptr];

endmodule
`default_nettype wire

// File: rtl/window_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_stream_gen
// Description : Turns a raster pixel stream into one zero-padded 3x3
//               neighbourhood per pixel, in raster order, using two line
//               buffers. After the last real pixel, WIDTH+1 zero pixels are
//               injected to push out the final windows.
//               Ports: clk, rst (sync, active high),
//                      bus (slave side of window_stream_gen_if)
// Revision    : 1.0 - initial release
// ============================================================================
module window_stream_gen
    import window_stream_gen_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    window_stream_gen_if.slave bus
);

    localparam int                 c_FLUSH_LEN = WIDTH + 1;
    localparam int                 c_CNT_W     = $clog2(c_FLUSH_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(c_FLUSH_LEN);
    localparam logic [COORD_W-1:0] c_X_LAST    = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] c_Y_LAST    = COORD_W'(DEPTH - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic               w_active;
    logic               w_can_move;
    logic               w_flush_more;
    logic               w_adv;
    logic               w_accept;
    logic               w_emit;
    logic               w_in_last;
    logic               w_taken;

    logic [PIX_W-1:0]   w_pix_shift;
    logic [PIX_W-1:0]   w_lb1_out;
    logic [PIX_W-1:0]   w_lb2_out;

    // r_tap[row][0] holds column dx=0, r_tap[row][1] holds column dx=+1;
    // row 0 is dy=-1 (two lines back), row 2 is dy=+1 (live stream).
    logic [PIX_W-1:0]   r_tap   [3][2];
    logic [PIX_W-1:0]   w_shift [3][3];
    logic [9*PIX_W-1:0] w_win_nxt;

    logic [COORD_W-1:0] r_in_x;
    logic [COORD_W-1:0] r_in_y;
    logic [COORD_W-1:0] r_next_x;
    logic [COORD_W-1:0] r_next_y;
    logic [c_CNT_W-1:0] r_fill_cnt;
    logic [c_CNT_W-1:0] r_flush_cnt;

    logic [9*PIX_W-1:0] r_win_out;
    logic [COORD_W-1:0] r_win_x;
    logic [COORD_W-1:0] r_win_y;
    logic               r_win_valid;

    logic               w_x_first;
    logic               w_x_last;
    logic               w_y_first;
    logic               w_y_last;

    // ------------------------------------------------------------------
    // Handshake / advance
    // ------------------------------------------------------------------
    assign w_active     = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_can_move   = !rst && (!r_win_valid || bus.win_ready);
    // Stop injecting zeros once the last window has been loaded, otherwise
    // the shift would produce windows past the end of the frame.
    assign w_flush_more = (r_state == ST_FLUSH) && (r_flush_cnt < c_CNT_FULL);
    assign w_adv        = w_can_move && ((w_active && bus.pix_valid) || w_flush_more);
    assign w_accept     = w_adv && w_active;
    assign w_emit       = w_adv && (r_fill_cnt == c_CNT_FULL);
    assign w_in_last    = (r_in_x == c_X_LAST) && (r_in_y == c_Y_LAST);
    assign w_taken      = r_win_valid && bus.win_ready;
    assign w_pix_shift  = w_active ? bus.pix_in : '0;

    // ------------------------------------------------------------------
    // Line buffers: lb1 delays by one line, lb2 by two
    // ------------------------------------------------------------------
    window_stream_gen_line_buffer #(
        .LEN   (WIDTH),
        .PIX_W (PIX_W)
    ) u_line_buffer_1 (
        .clk  (clk),
        .rst  (rst),
        .en   (w_adv),
        .din  (w_pix_shift),
        .dout (w_lb1_out)
    );

    window_stream_gen_line_buffer #(
        .LEN   (WIDTH),
        .PIX_W (PIX_W)
    ) u_line_buffer_2 (
        .clk  (clk),
        .rst  (rst),
        .en   (w_adv),
        .din  (w_lb1_out),
        .dout (w_lb2_out)
    );

    // ------------------------------------------------------------------
    // 3x3 neighbourhood as it will be after this advance
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_shift[r][0] = r_tap[r][0];
            w_shift[r][1] = r_tap[r][1];
        end
        w_shift[0][2] = w_lb2_out;
        w_shift[1][2] = w_lb1_out;
        w_shift[2][2] = w_pix_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                r_tap[r][0] <= '0;
                r_tap[r][1] <= '0;
            end
        end else if (w_adv) begin
            for (int r = 0; r < 3; r++) begin
                r_tap[r][0] <= r_tap[r][1];
                r_tap[r][1] <= w_shift[r][2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Border masking on the coordinates of the window being loaded. The
    // x tests also kill line-wrap taps, which hold pixels of the adjacent
    // line; the y tests kill stale line-buffer and flush contents.
    // ------------------------------------------------------------------
    assign w_x_first = (r_next_x == '0);
    assign w_x_last  = (r_next_x == c_X_LAST);
    assign w_y_first = (r_next_y == '0);
    assign w_y_last  = (r_next_y == c_Y_LAST);

    generate
        for (genvar r = 0; r < 3; r++) begin : g_row
            for (genvar c = 0; c < 3; c++) begin : g_col
                logic w_kill;
                assign w_kill = ((c == 0) && w_x_first) || ((c == 2) && w_x_last) ||
                                ((r == 0) && w_y_first) || ((r == 2) && w_y_last);
                assign w_win_nxt[(r*3 + c)*PIX_W +: PIX_W] = w_kill ? '0 : w_shift[r][c];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_x      <= '0;
            r_in_y      <= '0;
            r_next_x    <= '0;
            r_next_y    <= '0;
            r_fill_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                if (r_in_x == c_X_LAST) begin
                    r_in_x <= '0;
                    r_in_y <= (r_in_y == c_Y_LAST) ? '0 : r_in_y + 1'b1;
                end else begin
                    r_in_x <= r_in_x + 1'b1;
                end
            end
            if (w_emit) begin
                if (r_next_x == c_X_LAST) begin
                    r_next_x <= '0;
                    r_next_y <= (r_next_y == c_Y_LAST) ? '0 : r_next_y + 1'b1;
                end else begin
                    r_next_x <= r_next_x + 1'b1;
                end
            end
            if (r_state == ST_DONE) begin
                r_fill_cnt  <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_adv && (r_fill_cnt != c_CNT_FULL)) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                if (w_adv && (r_state == ST_FLUSH)) begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_out   <= '0;
            r_win_x     <= '0;
            r_win_y     <= '0;
        end else if (w_emit) begin
            r_win_valid <= 1'b1;
            r_win_out   <= w_win_nxt;
            r_win_x     <= r_next_x;
            r_win_y     <= r_next_y;
        end else if (bus.win_ready) begin
            r_win_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_in_last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && w_in_last) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_taken && (r_win_x == c_X_LAST) && (r_win_y == c_Y_LAST)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.pix_ready  = w_active && w_can_move;
    assign bus.win_out    = r_win_out;
    assign bus.win_x      = r_win_x;
    assign bus.win_y      = r_win_y;
    assign bus.win_valid  = r_win_valid;
    assign bus.frame_done = !rst && (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_window_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_stream_gen
// Description : Directed bench for window_stream_gen on a 4x3 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_stream_gen;
    import window_stream_gen_pkg::*;

    localparam int c_W  = 4;
    localparam int c_D  = 3;
    localparam int c_PW = 8;

    typedef struct packed {
        logic [71:0] w;
        logic [8:0]  x;
        logic [8:0]  y;
    } win_t;

    logic clk;
    logic rst;

    window_stream_gen_if #(.PIX_W(c_PW)) bus ();

    window_stream_gen #(
        .WIDTH (c_W),
        .DEPTH (c_D),
        .PIX_W (c_PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   acc_cnt, acc6_cyc, first_win_cyc, done_cnt, done_cyc, acc_after_done;
    bit   gap_mode = 1'b0;
    bit   bp_mode  = 1'b0;
    bit   bp_done  = 1'b0;
    int   bp_left  = 0;
    logic [7:0] pix_q[$];
    win_t       got[$];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hand-written window, taps listed k=0..8 (NW..SE)
    function automatic logic [71:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Reference neighbourhood: pixel (xx,yy) of a frame is base + yy*W + xx
    function automatic logic [71:0] exp_win(input int base, input int x, input int y);
        logic [71:0] w;
        int xx, yy, k;
        w = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                xx = x + dx;
                yy = y + dy;
                k  = (dy + 1) * 3 + (dx + 1);
                if (xx >= 0 && xx < c_W && yy >= 0 && yy < c_D)
                    w[k*8 +: 8] = 8'(base + yy * c_W + xx);
            end
        end
        return w;
    endfunction

    function automatic win_t at(input int i);
        win_t e;
        e = '0;
        if (i < got.size()) e = got[i];
        return e;
    endfunction

    task automatic clear_stats();
        acc_cnt        = 0;
        acc6_cyc       = -1;
        first_win_cyc  = -1;
        done_cnt       = 0;
        done_cyc       = -1;
        acc_after_done = -1;
        got.delete();
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < c_W * c_D; i++) pix_q.push_back(8'(base + i));
    endtask

    // One clock: drive at the negedge, sample 1ns later, wait next negedge
    task automatic tick();
        win_t e;
        if (bp_mode && !bp_done && bus.win_valid && bus.win_x == 9'd2 && bus.win_y == 9'd0) begin
            bp_left = 5;
            bp_done = 1'b1;
        end
        bus.pix_valid = (pix_q.size() > 0) && (!gap_mode || (cyc % 2 == 0));
        bus.pix_in    = (pix_q.size() > 0) ? pix_q[0] : 8'd0;
        bus.win_ready = (bp_left == 0);
        #1;
        if (bp_left > 0) begin
            chk("bp_hold_win", bus.win_out, pk(0, 0, 0, 2, 3, 4, 6, 7, 8));
            chk("bp_pix_ready", 72'(bus.pix_ready), 72'd0);
            bp_left--;
        end
        if (bus.pix_valid && bus.pix_ready) begin
            void'(pix_q.pop_front());
            acc_cnt++;
            if (acc_cnt == 6 && acc6_cyc < 0) acc6_cyc = cyc;
            if (done_cnt >= 1 && acc_after_done < 0) acc_after_done = cyc;
        end
        if (bus.win_valid && first_win_cyc < 0) first_win_cyc = cyc;
        if (bus.win_valid && bus.win_ready) begin
            e.w = bus.win_out;
            e.x = bus.win_x;
            e.y = bus.win_y;
            got.push_back(e);
        end
        if (bus.frame_done) begin
            if (done_cyc < 0) done_cyc = cyc;
            done_cnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input string tag, input int n_win, input int n_done, input int n_acc);
        int k;
        k = 0;
        while ((got.size() < n_win || done_cnt < n_done || acc_cnt < n_acc) && k < 400) begin
            tick();
            k++;
        end
        chk({tag, "_complete"},
            72'((got.size() >= n_win) && (done_cnt >= n_done) && (acc_cnt >= n_acc)), 72'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_frame(input string tag, input int off, input int base);
        win_t e;
        for (int i = 0; i < c_W * c_D; i++) begin
            e = at(off + i);
            chk($sformatf("%s_xy%0d", tag, i), 72'({e.x, e.y}),
                72'({9'(i % c_W), 9'(i / c_W)}));
            chk($sformatf("%s_taps%0d", tag, i), e.w, exp_win(base, i % c_W, i / c_W));
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.win_ready = 1'b1;
        clear_stats();

        // Reset state
        @(negedge clk);
        chk("rst_pix_ready", 72'(bus.pix_ready), 72'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_pix_ready", 72'(bus.pix_ready), 72'd1);
        chk("idle_win_valid", 72'(bus.win_valid), 72'd0);
        chk("idle_win_out", bus.win_out, 72'd0);
        chk("idle_win_xy", 72'({bus.win_x, bus.win_y}), 72'd0);
        chk("idle_frame_done", 72'(bus.frame_done), 72'd0);
        @(negedge clk);

        // Basic frame
        clear_stats();
        push_frame(1);
        run_until("basic", 12, 1, 12);
        idle(8);
        chk("basic_count", 72'(got.size()), 72'd12);
        chk("basic_done_cnt", 72'(done_cnt), 72'd1);
        chk("basic_latency", 72'(first_win_cyc), 72'(acc6_cyc + 1));
        chk("basic_w00", at(0).w, pk(0, 0, 0, 0, 1, 2, 0, 5, 6));
        chk("basic_w11", at(5).w, pk(1, 2, 3, 5, 6, 7, 9, 10, 11));
        chk("basic_w32", at(11).w, pk(7, 8, 0, 11, 12, 0, 0, 0, 0));
        chk("basic_w01_wrap", at(4).w, pk(0, 1, 2, 0, 5, 6, 0, 9, 10));
        check_frame("basic", 0, 1);

        // Backpressure at window (2,0)
        clear_stats();
        bp_mode = 1'b1;
        bp_done = 1'b0;
        push_frame(1);
        run_until("bp", 12, 1, 12);
        idle(8);
        bp_mode = 1'b0;
        chk("bp_triggered", 72'(bp_done), 72'd1);
        chk("bp_count", 72'(got.size()), 72'd12);
        chk("bp_done_cnt", 72'(done_cnt), 72'd1);
        check_frame("bp", 0, 1);

        // Input gaps
        clear_stats();
        gap_mode = 1'b1;
        push_frame(1);
        run_until("gap", 12, 1, 12);
        idle(8);
        gap_mode = 1'b0;
        chk("gap_count", 72'(got.size()), 72'd12);
        chk("gap_done_cnt", 72'(done_cnt), 72'd1);
        check_frame("gap", 0, 1);

        // Reset in the middle of a frame
        clear_stats();
        push_frame(1);
        run_until("pre_rst", 0, 0, 7);
        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        pix_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        push_frame(101);
        run_until("rst", 12, 1, 12);
        idle(8);
        chk("rst_first_win", at(0).w, pk(0, 0, 0, 0, 101, 102, 0, 105, 106));
        chk("rst_count", 72'(got.size()), 72'd12);
        chk("rst_done_cnt", 72'(done_cnt), 72'd1);
        check_frame("rst", 0, 101);

        // Back-to-back frames
        clear_stats();
        push_frame(1);
        push_frame(201);
        run_until("b2b", 24, 2, 24);
        idle(8);
        chk("b2b_count", 72'(got.size()), 72'd24);
        chk("b2b_done_cnt", 72'(done_cnt), 72'd2);
        chk("b2b_restart", 72'(acc_after_done), 72'(done_cyc + 1));
        check_frame("b2b_f1", 0, 1);
        check_frame("b2b_f2", 12, 201);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
